// File: rtl/graph_edge_streamer.sv
// CSR adjacency store: seeds start/end node indices, then streams successors of requested nodes.
// Optional macro GRAPH_EDGE_STREAMER_STALL_EN adds edge_ready backpressure on the edge bus.
`timescale 1ns/1ps
module graph_edge_streamer #(
   parameter int unsigned PARAM_NODE_IDX_WIDTH = 10,
   parameter int unsigned PARAM_COUNTER_WIDTH  = 4,
   parameter int unsigned PARAM_EDGE_DEPTH     = 4096
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            ld_node_en,
   input  logic [PARAM_NODE_IDX_WIDTH-1:0] ld_node_idx,
   input  logic [PARAM_COUNTER_WIDTH-1:0]  ld_degree,
   input  logic                            ld_edge_en,
   input  logic [PARAM_NODE_IDX_WIDTH-1:0] ld_edge_dst,
   input  logic [PARAM_NODE_IDX_WIDTH-1:0] cfg_start_node,
   input  logic [PARAM_NODE_IDX_WIDTH-1:0] cfg_end_node,
   input  logic                            run,
   input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx,
   input  logic                            node_req,
`ifdef GRAPH_EDGE_STREAMER_STALL_EN
   input  logic                            edge_ready,
`endif
   output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
   output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter,
   output logic                            edge_valid,
   output logic                            busy,
   output logic                            load_err
);

   localparam int unsigned NW    = PARAM_NODE_IDX_WIDTH;
   localparam int unsigned CW    = PARAM_COUNTER_WIDTH;
   localparam int unsigned NODES = 1 << NW;
   localparam int unsigned AW    = $clog2(PARAM_EDGE_DEPTH);
   localparam int unsigned PW    = AW + 1;

   typedef enum logic [2:0] {IDLE, SEED_START, SEED_END, READY, STREAM} state_e;

   state_e            state_q, state_d;
   logic              run_q;
   logic [PW-1:0]     wr_ptr_q;
   logic              load_err_q;
   logic [NODES-1:0]  node_vld_q;
   logic [CW-1:0]     degree_q [NODES];
   logic [AW-1:0]     offset_q [NODES];
   logic [NW-1:0]     edge_mem [PARAM_EDGE_DEPTH];
   logic [AW-1:0]     ptr_q, ptr_d, nxt_ptr, req_off;
   logic [CW-1:0]     rem_q, rem_d, cnt_q, cnt_d, req_deg;
   logic [NW-1:0]     idx_q, idx_d, req_idx;
   logic              valid_q, valid_d, busy_q, busy_d;
   logic              ready_w, full, node_wr, edge_wr;

`ifdef GRAPH_EDGE_STREAMER_STALL_EN
   assign ready_w = edge_ready;
`else
   assign ready_w = 1'b1;
`endif

   assign full    = (wr_ptr_q == PW'(PARAM_EDGE_DEPTH));
   assign node_wr = ld_node_en && !run;
   assign edge_wr = ld_edge_en && !run && !full;

   // A per-node valid bit stands in for clearing the degree table, so the tables can stay RAMs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         load_err_q <= 1'b0;
         node_vld_q <= '0;
      end else begin
         if (edge_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (ld_edge_en && !run && full) load_err_q <= 1'b1;
         if (node_wr) node_vld_q[ld_node_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (node_wr) begin
         degree_q[ld_node_idx] <= ld_degree;
         offset_q[ld_node_idx] <= wr_ptr_q[AW-1:0];
      end
      if (edge_wr) edge_mem[wr_ptr_q[AW-1:0]] <= ld_edge_dst;
   end

   assign req_deg = node_vld_q[node_idx] ? degree_q[node_idx] : '0;
   assign req_off = offset_q[node_idx];
   assign req_idx = (req_deg == '0) ? node_idx : edge_mem[req_off];
   assign nxt_ptr = ptr_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (run && !run_q) begin
               state_d = SEED_START;
               idx_d   = cfg_start_node;
               cnt_d   = CW'(1);
               valid_d = 1'b1;
            end
         end
         SEED_START: begin
            if (ready_w) begin
               state_d = SEED_END;
               idx_d   = cfg_end_node;
               cnt_d   = CW'(1);
               valid_d = 1'b1;
            end
         end
         SEED_END: begin
            if (ready_w) begin
               state_d = READY;
               idx_d   = '0;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         end
         READY: begin
            if (node_req) begin
               state_d = STREAM;
               ptr_d   = req_off;
               rem_d   = req_deg;
               idx_d   = req_idx;
               cnt_d   = req_deg;
               valid_d = 1'b1;
            end
         end
         STREAM: begin
            if (ready_w) begin
               if (rem_q > CW'(1)) begin
                  ptr_d = nxt_ptr;
                  rem_d = rem_q - 1'b1;
                  idx_d = edge_mem[nxt_ptr];
                  cnt_d = rem_q - 1'b1;
               end else if (rem_q == CW'(1) && node_req) begin
                  ptr_d = req_off;
                  rem_d = req_deg;
                  idx_d = req_idx;
                  cnt_d = req_deg;
               end else begin
                  state_d = READY;
                  idx_d   = '0;
                  cnt_d   = '0;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
      if (!run) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end
      busy_d = (state_d == SEED_START) || (state_d == SEED_END) || (state_d == STREAM);
   end

   // run_q resets high so a run level held through reset is not mistaken for a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         run_q   <= 1'b1;
         ptr_q   <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign next_node_idx     = idx_q;
   assign next_node_counter = cnt_q;
   assign edge_valid        = valid_q;
   assign busy              = busy_q;
   assign load_err          = load_err_q;

endmodule

// File: tb/tb_graph_edge_streamer.sv
// Directed bench for graph_edge_streamer: seeding, streaming, back-to-back, degree 0, overflow, reset.
`timescale 1ns/1ps
module tb_graph_edge_streamer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ld_node_en, ld_edge_en, run, node_req;
   logic [9:0] ld_node_idx, ld_edge_dst, cfg_start_node, cfg_end_node, node_idx;
   logic [3:0] ld_degree;
   logic [9:0] next_node_idx;
   logic [3:0] next_node_counter;
   logic       edge_valid, busy, load_err;
`ifdef GRAPH_EDGE_STREAMER_STALL_EN
   logic       edge_ready;
   logic       s_edge_ready;
`endif

   logic       s_ld_node_en, s_ld_edge_en, s_run, s_node_req;
   logic [9:0] s_ld_node_idx, s_ld_edge_dst, s_node_idx;
   logic [3:0] s_ld_degree;
   logic [9:0] s_next_node_idx;
   logic [3:0] s_next_node_counter;
   logic       s_edge_valid, s_busy, s_load_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   graph_edge_streamer u_dut (
      .clk(clk), .rst_n(rst_n),
      .ld_node_en(ld_node_en), .ld_node_idx(ld_node_idx), .ld_degree(ld_degree),
      .ld_edge_en(ld_edge_en), .ld_edge_dst(ld_edge_dst),
      .cfg_start_node(cfg_start_node), .cfg_end_node(cfg_end_node),
      .run(run), .node_idx(node_idx), .node_req(node_req),
`ifdef GRAPH_EDGE_STREAMER_STALL_EN
      .edge_ready(edge_ready),
`endif
      .next_node_idx(next_node_idx), .next_node_counter(next_node_counter),
      .edge_valid(edge_valid), .busy(busy), .load_err(load_err)
   );

   graph_edge_streamer #(.PARAM_EDGE_DEPTH(4)) u_small (
      .clk(clk), .rst_n(rst_n),
      .ld_node_en(s_ld_node_en), .ld_node_idx(s_ld_node_idx), .ld_degree(s_ld_degree),
      .ld_edge_en(s_ld_edge_en), .ld_edge_dst(s_ld_edge_dst),
      .cfg_start_node(10'd0), .cfg_end_node(10'd0),
      .run(s_run), .node_idx(s_node_idx), .node_req(s_node_req),
`ifdef GRAPH_EDGE_STREAMER_STALL_EN
      .edge_ready(s_edge_ready),
`endif
      .next_node_idx(s_next_node_idx), .next_node_counter(s_next_node_counter),
      .edge_valid(s_edge_valid), .busy(s_busy), .load_err(s_load_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // {valid, idx, counter} of the main instance
   task automatic expect_edge(input string tag, input int idx, input int cnt);
      check_eq(tag, 32'({edge_valid, next_node_idx, next_node_counter}),
               32'({1'b1, 10'(idx), 4'(cnt)}));
   endtask

   task automatic ld(input bit nen, input int nidx, input int deg, input bit een, input int dst);
      ld_node_en  = nen;
      ld_node_idx = 10'(nidx);
      ld_degree   = 4'(deg);
      ld_edge_en  = een;
      ld_edge_dst = 10'(dst);
      tick();
      ld_node_en  = 1'b0;
      ld_edge_en  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      {ld_node_en, ld_edge_en, run, node_req} = '0;
      {ld_node_idx, ld_edge_dst, cfg_start_node, cfg_end_node, node_idx} = '0;
      ld_degree = '0;
      {s_ld_node_en, s_ld_edge_en, s_run, s_node_req} = '0;
      {s_ld_node_idx, s_ld_edge_dst, s_node_idx} = '0;
      s_ld_degree = '0;
`ifdef GRAPH_EDGE_STREAMER_STALL_EN
      edge_ready   = 1'b1;
      s_edge_ready = 1'b1;
`endif
      repeat (3) tick();
      check_eq("reset_outputs", 32'({edge_valid, next_node_idx, next_node_counter, busy, load_err}), 0);
      rst_n = 1'b1;
      tick();

      // node 5 deg 3 {7,9,2}; node 11 deg 0
      ld(1, 5, 3, 1, 7);
      ld(0, 0, 0, 1, 9);
      ld(0, 0, 0, 1, 2);
      ld(1, 11, 0, 0, 0);
      cfg_start_node = 10'd5;
      cfg_end_node   = 10'd2;
      run = 1'b1;
      tick();
      expect_edge("seed_start", 5, 1);
      check_eq("seed_busy", 32'(busy), 1);
      tick();
      expect_edge("seed_end", 2, 1);
      tick();
      check_eq("ready_idle_bus", 32'({edge_valid, busy}), 0);
      node_idx = 10'd5;
      node_req = 1'b1;
      tick();
      expect_edge("s1_e0", 7, 3);
      node_idx = 10'd11;
      tick();
      expect_edge("s1_e1_req_ignored", 9, 2);
      tick();
      expect_edge("s1_e2_req_ignored", 2, 1);
      node_req = 1'b0;
      tick();
      check_eq("s1_done", 32'(edge_valid), 0);

      node_idx = 10'd11;
      node_req = 1'b1;
      tick();
      expect_edge("deg0", 11, 0);
      check_eq("deg0_busy", 32'(busy), 1);
      node_req = 1'b0;
      tick();
      check_eq("deg0_done", 32'(edge_valid), 0);

      // reload: node 5 deg 2 {3,4} at offset 3, node 3 deg 1 {8} at offset 5
      run = 1'b0;
      tick();
      check_eq("run_low_idle", 32'({edge_valid, busy}), 0);
      ld(1, 5, 2, 1, 3);
      ld(0, 0, 0, 1, 4);
      ld(1, 3, 1, 1, 8);
      run = 1'b1;
      repeat (3) tick();
      node_idx = 10'd5;
      node_req = 1'b1;
      tick();
      expect_edge("b2b_e0", 3, 2);
      node_idx = 10'd3;
      tick();
      expect_edge("b2b_e1", 4, 1);
      tick();
      expect_edge("b2b_e2", 8, 1);
      node_req = 1'b0;
      tick();
      check_eq("b2b_done", 32'(edge_valid), 0);

      // depth-4 instance: 5th append dropped; node 1 starts at offset 3 and wraps
      s_ld_edge_en = 1'b1;
      s_ld_edge_dst = 10'd10; tick();
      s_ld_edge_dst = 10'd11; tick();
      s_ld_edge_dst = 10'd12; tick();
      s_ld_node_en = 1'b1;
      s_ld_node_idx = 10'd1;
      s_ld_degree = 4'd3;
      s_ld_edge_dst = 10'd13; tick();
      s_ld_node_en = 1'b0;
      check_eq("ovf_err_before", 32'(s_load_err), 0);
      s_ld_edge_dst = 10'd14; tick();
      s_ld_edge_en = 1'b0;
      check_eq("ovf_err_set", 32'(s_load_err), 1);
      s_run = 1'b1;
      repeat (3) tick();
      s_node_idx = 10'd1;
      s_node_req = 1'b1;
      tick();
      s_node_req = 1'b0;
      check_eq("wrap_e0", 32'({s_edge_valid, s_next_node_idx, s_next_node_counter}), 32'({1'b1, 10'd13, 4'd3}));
      tick();
      check_eq("wrap_e1", 32'({s_edge_valid, s_next_node_idx, s_next_node_counter}), 32'({1'b1, 10'd10, 4'd2}));
      tick();
      check_eq("wrap_e2", 32'({s_edge_valid, s_next_node_idx, s_next_node_counter}), 32'({1'b1, 10'd11, 4'd1}));
      tick();
      check_eq("wrap_done", 32'(s_edge_valid), 0);
      check_eq("ovf_err_sticky", 32'(s_load_err), 1);

      // asynchronous reset mid-stream with rem=2
      node_idx = 10'd5;
      node_req = 1'b1;
      tick();
      node_req = 1'b0;
      expect_edge("rst_pre", 3, 2);
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_out", 32'({edge_valid, next_node_idx, next_node_counter, busy}), 0);
      check_eq("rst_clears_err", 32'(s_load_err), 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("post_rst_quiet", 32'(edge_valid), 0);
      end
      run = 1'b0;
      tick();
      run = 1'b1;
      tick();
      expect_edge("rerun_seed", 5, 1);
      tick();
      tick();
      node_idx = 10'd5;
      node_req = 1'b1;
      tick();
      node_req = 1'b0;
      expect_edge("cleared_deg0", 5, 0);
      tick();

`ifdef GRAPH_EDGE_STREAMER_STALL_EN
      run = 1'b0;
      tick();
      ld(1, 20, 3, 1, 7);
      ld(0, 0, 0, 1, 9);
      ld(0, 0, 0, 1, 2);
      run = 1'b1;
      repeat (3) tick();
      node_idx = 10'd20;
      node_req = 1'b1;
      tick();
      node_req = 1'b0;
      expect_edge("stall_e0", 7, 3);
      tick();
      expect_edge("stall_e1", 9, 2);
      edge_ready = 1'b0;
      tick();
      expect_edge("stall_hold1", 9, 2);
      tick();
      expect_edge("stall_hold2", 9, 2);
      edge_ready = 1'b1;
      tick();
      expect_edge("stall_e2", 2, 1);
      tick();
      check_eq("stall_done", 32'(edge_valid), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
